// File: rtl/fpga_cfg_serializer.sv
// Configuration-link transmitter: holds the backend in reset after power-up, then
// shifts a latched config word out MSB-first on o_sclk/o_sdout once i_ready is seen.
module fpga_cfg_serializer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIV     = 2,
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             i_mainclk,
    input  logic             i_resetbFPGA,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_resetbAll,
    output logic             o_sclk,
    output logic             o_sdout,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (RST_CYC > 0) ? $clog2(RST_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_RST_HOLD,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [RW-1:0]    r_rst_cnt;
    logic [HW-1:0]    r_half;
    logic [BW-1:0]    r_bit;
    logic [TW-1:0]    r_wait;
    logic             r_pending;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_shreg;
    logic             r_resetb_all;
    logic             r_sclk;
    logic             r_sdout;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_req;
    logic [WIDTH-1:0] w_word;
    logic             w_half_end;
    logic             w_last_bit;

    // A fresh i_start wins over a stale pending word so start+ready accepts at once.
    assign w_req      = i_start | r_pending;
    assign w_word     = i_start ? i_data : r_data;
    assign w_half_end = (r_half == HW'(DIV - 1));
    assign w_last_bit = (r_bit == '0);

    always_ff @(posedge i_mainclk) begin
        if (!i_resetbFPGA) begin
            r_state      <= S_RST_HOLD;
            r_rst_cnt    <= '0;
            r_half       <= '0;
            r_bit        <= '0;
            r_wait       <= '0;
            r_pending    <= 1'b0;
            r_data       <= '0;
            r_shreg      <= '0;
            r_resetb_all <= 1'b0;
            r_sclk       <= 1'b0;
            r_sdout      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RST_HOLD: begin
                    if (r_rst_cnt == RW'(RST_CYC)) begin
                        r_resetb_all <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_start) begin
                        r_data    <= i_data;
                        r_err     <= 1'b0;
                        r_wait    <= '0;
                        r_pending <= 1'b1;
                    end
                    if (w_req && i_ready) begin
                        r_pending <= 1'b0;
                        r_state   <= S_SHIFT;
                        r_busy    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_sdout   <= w_word[WIDTH-1];
                        r_shreg   <= {w_word[WIDTH-2:0], 1'b0};
                        r_bit     <= BW'(WIDTH - 1);
                        r_half    <= '0;
                    end else if (r_pending && !i_start && !i_ready) begin
                        // Give up on the backend after TIMEOUT wait cycles.
                        if (r_wait == TW'(TIMEOUT - 1)) begin
                            r_pending <= 1'b0;
                            r_err     <= 1'b1;
                            r_wait    <= '0;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_half <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else if (w_last_bit) begin
                            r_state <= S_DONE;
                            r_sclk  <= 1'b0;
                            r_sdout <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // Data only moves at the start of a low phase.
                            r_bit   <= r_bit - 1'b1;
                            r_sclk  <= 1'b0;
                            r_sdout <= r_shreg[WIDTH-1];
                            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_half <= r_half + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_RST_HOLD;
                end
            endcase
        end
    end

    assign o_resetbAll = r_resetb_all;
    assign o_sclk      = r_sclk;
    assign o_sdout     = r_sdout;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_fpga_cfg_serializer.sv
// Bench for fpga_cfg_serializer: frame-level reference model checked every cycle,
// plus directed scenarios pinned with literal expectations.
module tb_fpga_cfg_serializer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DIV     = 2;
    localparam int unsigned RST_CYC = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int          FR      = 2 * DIV * WIDTH;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] data  = '0;
    logic             o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_err;

    fpga_cfg_serializer #(
        .WIDTH(WIDTH), .DIV(DIV), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_mainclk   (clk),
        .i_resetbFPGA(rst_n),
        .i_start     (start),
        .i_data      (data),
        .i_ready     (ready),
        .o_resetbAll (o_resetbAll),
        .o_sclk      (o_sclk),
        .o_sdout     (o_sdout),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_since = edges since reset release, m_k = offset into the
    // current frame (FR is the done cycle, -1 when no frame).
    int               m_since = 0;
    int               m_k     = -1;
    int               m_wait  = 0;
    bit               m_pend  = 0;
    bit               m_prev  = 0;
    bit               m_err   = 0;
    logic [WIDTH-1:0] m_data  = '0;
    logic [WIDTH-1:0] m_fdata = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_since = 0; m_k = -1; m_pend = 0; m_err = 0; m_wait = 0;
        end else begin
            if (m_since < 1000) m_since++;
            if (m_k >= 0) begin
                m_k++;
                if (m_k > FR) m_k = -1;
            end else if (m_since >= int'(RST_CYC) + 2) begin
                m_prev = m_pend;
                if (start) begin
                    m_pend = 1; m_data = data; m_err = 0; m_wait = 0;
                end
                if ((start || m_prev) && ready) begin
                    m_k = 0; m_fdata = m_data; m_pend = 0;
                end else if (m_prev && !start && !ready) begin
                    m_wait++;
                    if (m_wait == int'(TIMEOUT)) begin
                        m_pend = 0; m_err = 1; m_wait = 0;
                    end
                end
            end
        end
    end

    bit chk_en = 0;
    bit e_busy, e_sclk, e_sdout, e_done, e_rstb;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy  = (m_k >= 0) && (m_k < FR);
            e_sclk  = e_busy && (((m_k / int'(DIV)) % 2) == 1);
            e_sdout = e_busy ? m_fdata[int'(WIDTH) - 1 - m_k / (2 * int'(DIV))] : 1'b0;
            e_done  = (m_k == FR);
            e_rstb  = (m_since >= int'(RST_CYC) + 1);
            chk("model_resetbAll", 32'(o_resetbAll), 32'(e_rstb));
            chk("model_busy",      32'(o_busy),      32'(e_busy));
            chk("model_sclk",      32'(o_sclk),      32'(e_sclk));
            chk("model_sdout",     32'(o_sdout),     32'(e_sdout));
            chk("model_done",      32'(o_done),      32'(e_done));
            chk("model_err",       32'(o_err),       32'(m_err));
        end
    end

    // Frame monitor: what the backend would sample on each o_sclk rise.
    int               cyc = 0, last_rise = -1, per_min = 1000, per_max = 0;
    int               rises = 0, busy_cnt = 0, done_cnt = 0;
    logic [WIDTH-1:0] cap = '0;
    logic             prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rises++;
            cap = {cap[WIDTH-2:0], o_sdout};
            if (last_rise >= 0) begin
                if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
        end
        prev_sclk = o_sclk;
        if (o_busy === 1'b1) busy_cnt++;
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        rises = 0; busy_cnt = 0; done_cnt = 0; cap = '0;
        last_rise = -1; per_min = 1000; per_max = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_len_check(input string name);
        int low = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_resetbAll !== 1'b0) break;
            low++;
        end
        chk(name, 32'(low), 32'(RST_CYC));
    endtask

    // Request a frame; ready stays low for delay edges counting the start edge.
    task automatic send(input logic [WIDTH-1:0] d, input int delay);
        start = 1'b1;
        data  = d;
        ready = (delay == 0);
        step(1);
        start = 1'b0;
        data  = WIDTH'($urandom);
        if (delay > 0) begin
            repeat (delay - 1) step(1);
            ready = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, input bit jitter);
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (o_done === 1'b1) begin
                start = 1'b0;
                return;
            end
            if (jitter) begin
                ready = 1'($urandom);
                start = ($urandom_range(0, 7) == 0);
                data  = WIDTH'($urandom);
            end
        end
        start = 1'b0;
        total++;
        bad++;
        $display("FAIL done_wait: no o_done within %0d cycles", budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int delay;
        step(1);
        chk_en = 1;
        step(1);
        chk("reset_resetbAll", 32'(o_resetbAll), 32'd0);
        chk("reset_sclk",      32'(o_sclk),      32'd0);
        chk("reset_sdout",     32'(o_sdout),     32'd0);
        chk("reset_busy_done_err", 32'({o_busy, o_done, o_err}), 32'd0);
        rst_n = 1'b1;
        hold_len_check("rst_hold_len");

        // 8'hA5 with ready already high.
        step(2);
        clear_mon();
        send(8'hA5, 0);
        wait_done(100, 0);
        step(2);
        chk("a5_captured", 32'(cap), 32'h0A5);
        chk("a5_rises", 32'(rises), 32'd8);
        chk("a5_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("a5_done_pulses", 32'(done_cnt), 32'd1);
        chk("a5_period_min", 32'(per_min), 32'd4);
        chk("a5_period_max", 32'(per_max), 32'd4);

        // Ready arrives 10 cycles after the request.
        clear_mon();
        send(8'h96, 10);
        chk("late_ready_not_busy", 32'(o_busy), 32'd0);
        step(1);
        chk("late_ready_busy", 32'(o_busy), 32'd1);
        chk("late_ready_err", 32'(o_err), 32'd0);
        wait_done(100, 0);
        step(2);
        chk("late_ready_captured", 32'(cap), 32'h096);

        // Ready never arrives.
        clear_mon();
        ready = 1'b0;
        start = 1'b1;
        data  = 8'h5A;
        step(1);
        start = 1'b0;
        step(int'(TIMEOUT) - 1);
        chk("timeout_err_early", 32'(o_err), 32'd0);
        step(1);
        chk("timeout_err_set", 32'(o_err), 32'd1);
        step(5);
        ready = 1'b1;
        step(3);
        chk("timeout_no_frame", 32'(o_busy), 32'd0);
        chk("timeout_no_rises", 32'(rises), 32'd0);
        chk("timeout_err_sticky", 32'(o_err), 32'd1);
        send(8'hC3, 0);
        chk("restart_clears_err", 32'(o_err), 32'd0);
        wait_done(100, 0);
        step(2);

        // Start pulsed mid-frame must not disturb the frame.
        clear_mon();
        send(8'h3C, 0);
        step(10);
        start = 1'b1;
        data  = 8'hFF;
        step(1);
        start = 1'b0;
        wait_done(100, 0);
        step(2);
        chk("midstart_captured", 32'(cap), 32'h03C);
        chk("midstart_rises", 32'(rises), 32'd8);

        // Reset during bit 3 aborts the frame.
        clear_mon();
        send(8'hE7, 0);
        step(17);
        chk("abort_busy_before", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("abort_sclk", 32'(o_sclk), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_resetbAll", 32'(o_resetbAll), 32'd0);
        rst_n = 1'b1;
        hold_len_check("abort_rst_hold_len");
        step(2);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Randomized traffic; the model checks every cycle.
        for (int n = 0; n < 40; n++) begin
            ready = 1'($urandom);
            step($urandom_range(0, 3));
            delay = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 12);
            send(WIDTH'($urandom), delay);
            if (delay - 1 >= int'(TIMEOUT)) begin
                step(2);
            end else begin
                wait_done(100, 1);
                step(1);
            end
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
